// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C core bus arbiter.
// Optional build macro: I2C_ARB_FIXED_PRIORITY_EN (see i2c_bus_arbiter.sv).
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        GAP
    } arb_state_t;

    // Register map of the i2c_opencores Avalon-MM slave
    localparam logic [2:0] PRER_LO = 3'd0;
    localparam logic [2:0] PRER_HI = 3'd1;
    localparam logic [2:0] CTR     = 3'd2;
    localparam logic [2:0] TXR_RXR = 3'd3;
    localparam logic [2:0] CR_SR   = 3'd4;

    localparam int DEFAULT_TIMEOUT_CYC = 1000000;

endpackage

// File: rtl/i2c_arb_rr_pick.sv
// Rotating priority encoder: first requester at or after i_ptr, wrapping modulo N_REQ.
// Used with i_ptr tied to zero, it becomes a plain lowest-index-first encoder.
module i2c_arb_rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin : pick
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] pos;
        sum      = '0;
        pos      = '0;
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            pos = sum[IDX_W-1:0];
            if (!o_valid && i_req[pos]) begin
                o_valid       = 1'b1;
                o_onehot[pos] = 1'b1;
                o_idx         = pos;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Bus-locking arbiter sharing one i2c_opencores register port between N_REQ masters.
// Define I2C_ARB_FIXED_PRIORITY_EN for lowest-index-first instead of round-robin.
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int TO_W        = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    input  logic [N_REQ*ADDR_W-1:0]  m_address,
    input  logic [N_REQ-1:0]         m_read,
    input  logic [N_REQ-1:0]         m_write,
    input  logic [N_REQ*DATA_W-1:0]  m_writedata,
    output logic [DATA_W-1:0]        m_readdata,
    output logic [N_REQ-1:0]         m_waitrequest,
    output logic [ADDR_W-1:0]        s_address,
    output logic                     s_read,
    output logic                     s_write,
    output logic [DATA_W-1:0]        s_writedata,
    input  logic [DATA_W-1:0]        s_readdata,
    input  logic                     s_waitrequest,
    output logic [N_REQ-1:0]         timeout_err,
    input  logic                     err_clr
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t       r_state, w_nextState;
    logic [N_REQ-1:0] r_grant, w_nextGrant;
    logic [N_REQ-1:0] r_timeoutErr, w_errSet;
    logic [IDX_W-1:0] r_owner, w_nextOwner;
    logic [TO_W-1:0]  r_wdog, w_nextWdog;
    logic             r_toPend, w_nextToPend;
    logic [IDX_W-1:0] w_ptr, w_pickIdx;
    logic [N_REQ-1:0] w_pickOneHot;
    logic             w_pickValid;
    logic             w_own, w_strobe, w_inFlight, w_accepted, w_expired, w_release;

`ifdef I2C_ARB_FIXED_PRIORITY_EN
    assign w_ptr = '0;
`else
    logic [IDX_W-1:0] r_rrPtr;

    // Next search starts just past whoever last released or was revoked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rrPtr <= '0;
        end else if (w_release) begin
            r_rrPtr <= (r_owner == IDX_W'(N_REQ-1)) ? '0 : r_owner + 1'b1;
        end
    end

    assign w_ptr = r_rrPtr;
`endif

    i2c_arb_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (w_ptr),
        .o_onehot (w_pickOneHot),
        .o_idx    (w_pickIdx),
        .o_valid  (w_pickValid)
    );

    assign w_own       = (r_state == OWN);
    assign s_address   = w_own ? m_address[r_owner*ADDR_W +: ADDR_W] : '0;
    assign s_writedata = w_own ? m_writedata[r_owner*DATA_W +: DATA_W] : '0;
    assign s_read      = w_own & m_read[r_owner];
    assign s_write     = w_own & m_write[r_owner];
    assign m_readdata  = s_readdata;
    assign grant       = r_grant;
    assign timeout_err = r_timeoutErr;

    always_comb begin
        m_waitrequest = '1;
        if (w_own) begin
            m_waitrequest[r_owner] = s_waitrequest;
        end
    end

    assign w_strobe   = s_read | s_write;
    assign w_inFlight = w_strobe & s_waitrequest;
    assign w_accepted = w_strobe & ~s_waitrequest;
    // Expiry latches in r_toPend so a long in-flight access cannot mask it
    assign w_expired  = r_toPend | (~w_accepted & (r_wdog >= TO_W'(TIMEOUT_CYC - 1)));

    always_comb begin
        w_nextState  = r_state;
        w_nextGrant  = r_grant;
        w_nextOwner  = r_owner;
        w_nextWdog   = r_wdog;
        w_nextToPend = r_toPend;
        w_errSet     = '0;
        w_release    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pickValid) begin
                    w_nextState  = OWN;
                    w_nextGrant  = w_pickOneHot;
                    w_nextOwner  = w_pickIdx;
                    w_nextWdog   = '0;
                    w_nextToPend = 1'b0;
                end
            end
            OWN: begin
                if (!w_inFlight && (!req[r_owner] || w_expired)) begin
                    w_release    = 1'b1;
                    w_nextState  = GAP;
                    w_nextGrant  = '0;
                    w_nextToPend = 1'b0;
                    if (req[r_owner]) begin
                        w_errSet[r_owner] = 1'b1;
                    end
                end else begin
                    w_nextToPend = w_expired;
                    if (w_accepted) begin
                        w_nextWdog = '0;
                    end else if (!w_expired) begin
                        w_nextWdog = r_wdog + 1'b1;
                    end
                end
            end
            GAP:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_wdog       <= '0;
            r_toPend     <= 1'b0;
            r_timeoutErr <= '0;
        end else begin
            r_state      <= w_nextState;
            r_grant      <= w_nextGrant;
            r_owner      <= w_nextOwner;
            r_wdog       <= w_nextWdog;
            r_toPend     <= w_nextToPend;
            r_timeoutErr <= (err_clr ? '0 : r_timeoutErr) | w_errSet;
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against an ownership-level reference model.
module tb_i2c_bus_arbiter;

    localparam int N   = 3;
    localparam int AW  = 3;
    localparam int DW  = 8;
    localparam int TO  = 16;
    localparam int TOW = 20;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, grant, m_read, m_write, m_waitrequest, timeout_err;
    logic [N*AW-1:0] m_address;
    logic [N*DW-1:0] m_writedata;
    logic [DW-1:0]   m_readdata, s_writedata, s_readdata;
    logic [AW-1:0]   s_address;
    logic            s_read, s_write, s_waitrequest, err_clr;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, and the bookkeeping the rules need
    int           mOwner;
    bit           mGap;
    int           mPtr;
    int           mIdle;
    bit           mPend;
    logic [N-1:0] mErr;

    logic [AW-1:0] addrTable [5] = '{i2c_arb_pkg::PRER_LO, i2c_arb_pkg::PRER_HI,
                                     i2c_arb_pkg::CTR, i2c_arb_pkg::TXR_RXR,
                                     i2c_arb_pkg::CR_SR};

    i2c_bus_arbiter #(
        .N_REQ       (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO),
        .TO_W        (TOW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .grant         (grant),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .s_address     (s_address),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .s_waitrequest (s_waitrequest),
        .timeout_err   (timeout_err),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mOwner = -1;
        mGap   = 1'b0;
        mPtr   = 0;
        mIdle  = 0;
        mPend  = 1'b0;
        mErr   = '0;
    endtask

    function automatic int pickReq(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Advance the model by one clock using the inputs present at the edge
    task automatic modelUpdate();
        logic [N-1:0] setBits;
        bit strobe, busy, took, late;
        int start, p;
        setBits = '0;
        if (mGap) begin
            mGap = 1'b0;
        end else if (mOwner < 0) begin
`ifdef I2C_ARB_FIXED_PRIORITY_EN
            start = 0;
`else
            start = mPtr;
`endif
            p = pickReq(req, start);
            if (p >= 0) begin
                mOwner = p;
                mIdle  = 0;
                mPend  = 1'b0;
            end
        end else begin
            strobe = m_read[mOwner] | m_write[mOwner];
            busy   = strobe & s_waitrequest;
            took   = strobe & !s_waitrequest;
            late   = mPend || (!took && (mIdle + 1 >= TO));
            if (!busy && (!req[mOwner] || late)) begin
                if (req[mOwner]) setBits[mOwner] = 1'b1;
                mPtr   = (mOwner + 1) % N;
                mOwner = -1;
                mGap   = 1'b1;
                mPend  = 1'b0;
            end else begin
                if (late) mPend = 1'b1;
                mIdle = took ? 0 : mIdle + 1;
            end
        end
        mErr = (err_clr ? '0 : mErr) | setBits;
    endtask

    task automatic checkModel(input string tag);
        logic [N-1:0] eG, eW;
        logic eR, eWr;
        eG  = '0;
        eW  = '1;
        eR  = 1'b0;
        eWr = 1'b0;
        if (mOwner >= 0) begin
            eG[mOwner] = 1'b1;
            eW[mOwner] = s_waitrequest;
            eR         = m_read[mOwner];
            eWr        = m_write[mOwner];
        end
        checkOutput({tag, ".grant"}, 32'(grant), 32'(eG));
        checkOutput({tag, ".waitreq"}, 32'(m_waitrequest), 32'(eW));
        checkOutput({tag, ".s_read"}, 32'(s_read), 32'(eR));
        checkOutput({tag, ".s_write"}, 32'(s_write), 32'(eWr));
        checkOutput({tag, ".tmo_err"}, 32'(timeout_err), 32'(mErr));
        checkOutput({tag, ".rdata"}, 32'(m_readdata), 32'(s_readdata));
        if (mOwner >= 0) begin
            checkOutput({tag, ".s_addr"}, 32'(s_address), 32'(m_address[mOwner*AW +: AW]));
            checkOutput({tag, ".s_wdata"}, 32'(s_writedata), 32'(m_writedata[mOwner*DW +: DW]));
        end
    endtask

    // Inputs are already driven (just after a falling edge); check, clock, re-sync
    task automatic applyStimulus(input string tag);
        #1;
        checkModel(tag);
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        req = '0; m_read = '0; m_write = '0; err_clr = 1'b0; s_waitrequest = 1'b0;
        modelReset();
        #1;
        checkModel("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic setMaster(input int i, input logic rd, input logic wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_read[i]              = rd;
        m_write[i]             = wr;
        m_address[i*AW +: AW]  = a;
        m_writedata[i*DW +: DW] = d;
    endtask

    initial begin
        logic [N-1:0] expG;
        int rnd;
        reset = 1'b1; req = '0; m_read = '0; m_write = '0; m_address = '0;
        m_writedata = '0; s_readdata = 8'h00; s_waitrequest = 1'b0; err_clr = 1'b0;
        modelReset();
        @(negedge clk);
        checkOutput("rst.grant", 32'(grant), 32'h0);
        checkOutput("rst.waitreq", 32'(m_waitrequest), 32'h7);
        checkOutput("rst.s_read", 32'(s_read), 32'h0);
        checkOutput("rst.s_write", 32'(s_write), 32'h0);
        checkOutput("rst.tmo_err", 32'(timeout_err), 32'h0);
        reset = 1'b0;

        $display("[TB] single owner write");
        req = 3'b001;
        applyStimulus("t1.req");
        checkOutput("t1.grant", 32'(grant), 32'h1);
        setMaster(0, 1'b0, 1'b1, i2c_arb_pkg::TXR_RXR, 8'hA5);
        s_waitrequest = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checkOutput("t1.s_write", 32'(s_write), 32'h1);
            checkOutput("t1.s_wdata", 32'(s_writedata), 32'hA5);
            checkOutput("t1.wait_hi", 32'(m_waitrequest), 32'h7);
            applyStimulus("t1.busy");
        end
        s_waitrequest = 1'b0;
        #1;
        checkOutput("t1.wait_lo", 32'(m_waitrequest), 32'h6);
        applyStimulus("t1.accept");
        setMaster(0, 1'b0, 1'b0, '0, '0);
        req = 3'b000;
        applyStimulus("t1.release");
        checkOutput("t1.gap_grant", 32'(grant), 32'h0);
        applyStimulus("t1.gap");

        $display("[TB] round robin");
        doReset();
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            applyStimulus("t2.idle");
            expG = '0;
            expG[k % N] = 1'b1;
            checkOutput("t2.grant", 32'(grant), 32'(expG));
            setMaster(k % N, 1'b0, 1'b1, i2c_arb_pkg::CTR, 8'(k));
            applyStimulus("t2.access");
            setMaster(k % N, 1'b0, 1'b0, '0, '0);
            req[k % N] = 1'b0;
            applyStimulus("t2.drop");
            checkOutput("t2.gap", 32'(grant), 32'h0);
            req = 3'b111;
            applyStimulus("t2.gap");
        end
        req = '0;
        applyStimulus("t2.end0");
        applyStimulus("t2.end1");
        applyStimulus("t2.end2");

        $display("[TB] non-owner held off");
        doReset();
        req = 3'b001;
        applyStimulus("t3.grant0");
        req = 3'b011;
        setMaster(1, 1'b1, 1'b0, i2c_arb_pkg::CR_SR, 8'h00);
        #1;
        checkOutput("t3.hold_wait", 32'(m_waitrequest[1]), 32'h1);
        checkOutput("t3.hold_sread", 32'(s_read), 32'h0);
        applyStimulus("t3.hold");
        req = 3'b010;
        applyStimulus("t3.release0");
        applyStimulus("t3.gap");
        applyStimulus("t3.idle");
        s_readdata = 8'h3C;
        #1;
        checkOutput("t3.grant1", 32'(grant), 32'h2);
        checkOutput("t3.sread", 32'(s_read), 32'h1);
        checkOutput("t3.rdata", 32'(m_readdata), 32'h3C);
        checkOutput("t3.wait1", 32'(m_waitrequest), 32'h5);
        applyStimulus("t3.read");
        setMaster(1, 1'b0, 1'b0, '0, '0);
        req = '0;
        applyStimulus("t3.end0");
        applyStimulus("t3.end1");

        $display("[TB] release mid-access");
        doReset();
        req = 3'b001;
        applyStimulus("t4.grant");
        setMaster(0, 1'b0, 1'b1, i2c_arb_pkg::PRER_LO, 8'h5A);
        s_waitrequest = 1'b1;
        req = '0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus("t4.busy");
            checkOutput("t4.held", 32'(grant), 32'h1);
        end
        s_waitrequest = 1'b0;
        applyStimulus("t4.accept");
        checkOutput("t4.cleared", 32'(grant), 32'h0);
        setMaster(0, 1'b0, 1'b0, '0, '0);
        applyStimulus("t4.gap");

        $display("[TB] watchdog");
        doReset();
        req = 3'b100;
        applyStimulus("t5.grant");
        for (int c = 0; c < TO - 1; c++) begin
            applyStimulus("t5.idle");
            checkOutput("t5.owned", 32'(grant), 32'h4);
        end
        checkOutput("t5.noerr", 32'(timeout_err), 32'h0);
        applyStimulus("t5.expire");
        checkOutput("t5.revoked", 32'(grant), 32'h0);
        checkOutput("t5.err", 32'(timeout_err), 32'h4);
        req = '0;
        applyStimulus("t5.gap");
        checkOutput("t5.sticky", 32'(timeout_err), 32'h4);
        err_clr = 1'b1;
        applyStimulus("t5.clr");
        err_clr = 1'b0;
        checkOutput("t5.cleared", 32'(timeout_err), 32'h0);

        $display("[TB] lowest-index patterns");
        doReset();
        for (int k = 0; k < 3; k++) begin
            req = 3'b110;
            applyStimulus("t6.a");
            checkOutput("t6.grant_a", 32'(grant), 32'h2);
            req = '0;
            applyStimulus("t6.a_rel");
            applyStimulus("t6.a_gap");
            req = 3'b011;
            applyStimulus("t6.b");
            checkOutput("t6.grant_b", 32'(grant), 32'h1);
            req = '0;
            applyStimulus("t6.b_rel");
            applyStimulus("t6.b_gap");
        end

        $display("[TB] randomized traffic");
        doReset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(5) == 0) req[i] = ~req[i];
                rnd = int'($urandom_range(7));
                setMaster(i, (i != 2) && (rnd == 0), (i != 2) && (rnd == 1),
                          addrTable[$urandom_range(4)], DW'($urandom));
            end
            s_waitrequest = 1'($urandom_range(1));
            s_readdata    = DW'($urandom);
            err_clr       = ($urandom_range(31) == 0);
            applyStimulus("rand");
        end
        err_clr = 1'b0;

        $display("[TB] reset mid-access");
        doReset();
        req = 3'b001;
        applyStimulus("t7.grant");
        setMaster(0, 1'b0, 1'b1, i2c_arb_pkg::CR_SR, 8'h90);
        s_waitrequest = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t7.grant", 32'(grant), 32'h0);
        checkOutput("t7.s_write", 32'(s_write), 32'h0);
        checkOutput("t7.waitreq", 32'(m_waitrequest), 32'h7);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        req = '0;
        setMaster(0, 1'b0, 1'b0, '0, '0);
        applyStimulus("t7.after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
